bcp_unit: RTL and testbench

- Boolean-constraint-propagation engine downstream of the solver control FSM.
- Accepts the clause-index stream issued during BCP_CORE and evaluates each clause against the current variable assignment.
- Pushes unit implications into the imply queue.
- Raises a sticky conflict flag when a clause is falsified.
- Drives bcp_busy, which the control FSM polls in BCP_WAIT.

---
 rtl/bcp_unit.sv | 190 +++++++++++++++++++
 tb/tb_bcp_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcp_unit.sv
// Boolean-constraint-propagation unit: buffers clause indices, evaluates each clause
// against the variable state and emits unit implications or a sticky conflict.
module bcp_unit #(
   parameter int unsigned MAX_CLAUSES_BITS = 8,
   parameter int unsigned MAX_VARS_BITS    = 8,
   parameter int unsigned LITS             = 3,
   parameter int unsigned FIFO_DEPTH       = 8
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              reset_bcp,
   input  logic                              bcp_en,
   input  logic [MAX_CLAUSES_BITS-1:0]       bcp_clause_idx,
   output logic                              bcp_busy,
   output logic                              conflict,
   output logic                              overflow,
   output logic                              cdb_read,
   output logic [MAX_CLAUSES_BITS-1:0]       cdb_idx,
   input  logic [LITS*(MAX_VARS_BITS+2)-1:0] cdb_lits,
   output logic                              vs_read,
   output logic [MAX_VARS_BITS-1:0]          vs_var,
   input  logic                              vs_val,
   input  logic                              vs_unassign,
   output logic                              push_imply,
   output logic [MAX_VARS_BITS-1:0]          var_in_imply,
   output logic                              val_in_imply,
   output logic                              type_in_imply,
   input  logic                              full_imply
);
   localparam int unsigned SW = MAX_VARS_BITS + 2;
   localparam int unsigned KW = $clog2(LITS + 1);
   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {IDLE, WAIT_CL, LIT_REQ, LIT_CHK, EVAL, PUSH} state_t;

   state_t                    state_q, state_d;
   logic [LITS-1:0][SW-1:0]   lits_q, lits_d;
   logic [KW-1:0]             k_q, k_d, unas_q, unas_d, fals_q, fals_d;
   logic [MAX_VARS_BITS-1:0]  ivar_q, ivar_d;
   logic                      ipol_q, ipol_d;
   logic [SW-1:0]             slot;

   logic [MAX_CLAUSES_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]             head_q, tail_q;
   logic [CW-1:0]             count_q;
   logic                      clr, fifo_empty, fifo_full, enq, drop, set_conflict;
   logic                      cdb_read_c, vs_read_c, push_c;

   assign clr        = reset | reset_bcp;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   // a pop in the same cycle frees a slot, so a full FIFO still accepts
   assign enq        = bcp_en & ~conflict & (~fifo_full | cdb_read_c);
   assign drop       = bcp_en & ~conflict & fifo_full & ~cdb_read_c;

   assign bcp_busy      = bcp_en | ~fifo_empty | (state_q != IDLE);
   assign cdb_read      = cdb_read_c & ~clr;
   assign cdb_idx       = cdb_read ? mem[head_q] : '0;
   assign vs_read       = vs_read_c & ~clr;
   assign vs_var        = vs_read ? slot[MAX_VARS_BITS-1:0] : '0;
   assign push_imply    = push_c & ~clr;
   assign var_in_imply  = push_imply ? ivar_q : '0;
   assign val_in_imply  = push_imply & ipol_q;
   assign type_in_imply = push_imply;

   // current literal slot selected by k
   always_comb begin
      slot = '0;
      for (int i = 0; i < LITS; i++)
         if (k_q == KW'(i)) slot = lits_q[i];
   end

   // next-state and strobe decode
   always_comb begin
      state_d      = state_q;
      lits_d       = lits_q;
      k_d          = k_q;
      unas_d       = unas_q;
      fals_d       = fals_q;
      ivar_d       = ivar_q;
      ipol_d       = ipol_q;
      set_conflict = 1'b0;
      cdb_read_c   = 1'b0;
      vs_read_c    = 1'b0;
      push_c       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && !conflict) begin
               cdb_read_c = 1'b1;
               state_d    = WAIT_CL;
            end
         end
         WAIT_CL: begin
            lits_d  = cdb_lits;
            k_d     = '0;
            unas_d  = '0;
            fals_d  = '0;
            state_d = LIT_REQ;
         end
         LIT_REQ: begin
            if (slot[SW-1]) begin
               vs_read_c = 1'b1;
               state_d   = LIT_CHK;
            end else begin
               k_d = k_q + KW'(1);
               if (k_q == KW'(LITS - 1)) state_d = EVAL;
            end
         end
         LIT_CHK: begin
            if (!vs_unassign && (vs_val == slot[SW-2])) begin
               state_d = IDLE;
            end else begin
               if (vs_unassign) begin
                  unas_d = unas_q + KW'(1);
                  ivar_d = slot[MAX_VARS_BITS-1:0];
                  ipol_d = slot[SW-2];
               end else begin
                  fals_d = fals_q + KW'(1);
               end
               k_d     = k_q + KW'(1);
               state_d = (k_q == KW'(LITS - 1)) ? EVAL : LIT_REQ;
            end
         end
         EVAL: begin
            if (unas_q == '0) begin
               set_conflict = 1'b1;
               state_d      = IDLE;
            end else if (unas_q == KW'(1)) begin
               state_d = PUSH;
            end else begin
               state_d = IDLE;
            end
         end
         PUSH: begin
            if (!full_imply) begin
               push_c  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clr) begin
         state_q <= IDLE;
         lits_q  <= '0;
         k_q     <= '0;
         unas_q  <= '0;
         fals_q  <= '0;
         ivar_q  <= '0;
         ipol_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lits_q  <= lits_d;
         k_q     <= k_d;
         unas_q  <= unas_d;
         fals_q  <= fals_d;
         ivar_q  <= ivar_d;
         ipol_q  <= ipol_d;
      end
   end

   // index FIFO bookkeeping; a conflict flushes it and blocks further work
   always_ff @(posedge clock) begin
      if (clr) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         conflict <= 1'b0;
         overflow <= 1'b0;
      end else if (set_conflict) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         conflict <= 1'b1;
      end else begin
         if (enq)        tail_q <= tail_q + PW'(1);
         if (cdb_read_c) head_q <= head_q + PW'(1);
         count_q <= count_q + CW'(enq) - CW'(cdb_read_c);
         if (drop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (enq) mem[tail_q] <= bcp_clause_idx;
   end

endmodule

// File: tb/tb_bcp_unit.sv
// Bench for bcp_unit: directed scenarios plus random traffic, checked cycle by cycle
// against a clause-timeline reference model driven by the same clause/variable tables.
module tb_bcp_unit;
   localparam int unsigned CB = 8, VB = 8, LITS = 3, DEPTH = 8;
   localparam int unsigned SW = VB + 2, LW = LITS * SW;

   logic          clock = 1'b0;
   logic          reset, reset_bcp, bcp_en, full_imply, vs_val, vs_unassign;
   logic [CB-1:0] bcp_clause_idx, cdb_idx;
   logic [LW-1:0] cdb_lits;
   logic          bcp_busy, conflict, overflow, cdb_read, vs_read, push_imply;
   logic [VB-1:0] vs_var, var_in_imply;
   logic          val_in_imply, type_in_imply;

   bcp_unit #(.MAX_CLAUSES_BITS(CB), .MAX_VARS_BITS(VB), .LITS(LITS), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .reset_bcp(reset_bcp), .bcp_en(bcp_en),
      .bcp_clause_idx(bcp_clause_idx), .bcp_busy(bcp_busy), .conflict(conflict),
      .overflow(overflow), .cdb_read(cdb_read), .cdb_idx(cdb_idx), .cdb_lits(cdb_lits),
      .vs_read(vs_read), .vs_var(vs_var), .vs_val(vs_val), .vs_unassign(vs_unassign),
      .push_imply(push_imply), .var_in_imply(var_in_imply), .val_in_imply(val_in_imply),
      .type_in_imply(type_in_imply), .full_imply(full_imply));

   always #5 clock = ~clock;

   logic [LW-1:0] db [256];
   bit            asg [256];
   bit            val [256];
   logic [LW-1:0] rw;

   int unsigned n_checks = 0, n_pass = 0, cyc = 0;

   // reference model: FIFO contents plus the timeline of the clause in flight
   int unsigned mq[$];
   int unsigned vs_at[$], vs_v[$];
   bit          m_conf, m_ovf, m_pend, m_ppol;
   int unsigned m_free, m_pend_from, m_pvar;
   int          m_conf_at;
   bit          e_busy, e_cdb, e_vs, e_push;
   int unsigned e_idx, e_vvar;
   int unsigned n_cdb, n_vs, n_push, n_busy0;
   int unsigned pop_cyc[$];

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [SW-1:0] lit(bit v, bit p, int unsigned x);
      return {v, p, VB'(x)};
   endfunction

   // lay out the cycles of a clause popped at cycle p from the literal rules
   task automatic schedule(int unsigned p, int unsigned idx);
      logic [LW-1:0] w;
      logic [SW-1:0] sl;
      int unsigned   t, nun, uv, vr;
      bit            up, pl;
      w = db[idx]; t = p + 2; nun = 0; uv = 0; up = 1'b0;
      for (int s = 0; s < LITS; s++) begin
         sl = w[s*SW +: SW];
         if (!sl[SW-1]) begin
            t += 1;
            continue;
         end
         vr = int'(sl[VB-1:0]);
         pl = sl[VB];
         vs_at.push_back(t);
         vs_v.push_back(vr);
         t += 2;
         if (asg[vr] && val[vr] == pl) begin
            m_free = t;
            return;
         end
         if (!asg[vr]) begin
            nun++; uv = vr; up = pl;
         end
      end
      m_free = t + 1;
      if (nun == 0) m_conf_at = int'(t);
      else if (nun == 1) begin
         m_pend = 1'b1; m_pend_from = t + 1; m_pvar = uv; m_ppol = up;
      end
   endtask

   task automatic model_expect();
      bit rst;
      rst = reset | reset_bcp;
      e_cdb = 0; e_vs = 0; e_push = 0; e_idx = 0; e_vvar = 0;
      e_busy = bcp_en || mq.size() != 0 || cyc < m_free || m_pend;
      if (!rst) begin
         if (vs_at.size() != 0 && vs_at[0] == cyc) begin
            e_vs = 1; e_vvar = vs_v[0];
         end
         if (m_pend && cyc >= m_pend_from && !full_imply) e_push = 1;
         if (!m_pend && cyc >= m_free && mq.size() != 0 && !m_conf) begin
            e_cdb = 1; e_idx = mq[0];
         end
      end
   endtask

   task automatic model_edge();
      if (reset || reset_bcp) begin
         mq.delete(); vs_at.delete(); vs_v.delete();
         m_conf = 0; m_ovf = 0; m_pend = 0; m_free = 0; m_conf_at = -1;
      end else begin
         if (e_push) begin
            m_pend = 0; m_free = cyc + 1;
         end
         if (bcp_en && !m_conf) begin
            if (mq.size() < DEPTH || e_cdb) mq.push_back(int'(bcp_clause_idx));
            else m_ovf = 1;
         end
         if (e_cdb) begin
            void'(mq.pop_front());
            schedule(cyc, e_idx);
         end
         if (m_conf_at == int'(cyc)) begin
            mq.delete(); m_conf = 1; m_conf_at = -1;
         end
         if (e_vs) begin
            void'(vs_at.pop_front());
            void'(vs_v.pop_front());
         end
      end
      cyc++;
   endtask

   // one clock: compare at negedge, advance model at posedge, then answer reads
   task automatic step();
      logic rd, vr;
      logic [CB-1:0] ri;
      logic [VB-1:0] vv;
      @(negedge clock);
      model_expect();
      check("busy", 32'(bcp_busy), 32'(e_busy));
      check("cdb_read", 32'(cdb_read), 32'(e_cdb));
      if (e_cdb) check("cdb_idx", 32'(cdb_idx), e_idx);
      check("vs_read", 32'(vs_read), 32'(e_vs));
      if (e_vs) check("vs_var", 32'(vs_var), e_vvar);
      check("push_imply", 32'(push_imply), 32'(e_push));
      if (e_push) begin
         check("imply_var", 32'(var_in_imply), m_pvar);
         check("imply_val", 32'(val_in_imply), 32'(m_ppol));
         check("imply_type", 32'(type_in_imply), 32'd1);
      end
      check("conflict", 32'(conflict), 32'(m_conf));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (bcp_busy !== 1'b1) n_busy0++;
      if (cdb_read === 1'b1) begin n_cdb++; pop_cyc.push_back(cyc); end
      if (vs_read === 1'b1) n_vs++;
      if (push_imply === 1'b1) n_push++;
      rd = cdb_read; ri = cdb_idx; vr = vs_read; vv = vs_var;
      @(posedge clock);
      model_edge();
      #1;
      cdb_lits = (rd === 1'b1) ? db[ri] : LW'($urandom());
      if (vr === 1'b1) begin
         vs_unassign = !asg[vv];
         vs_val      = asg[vv] ? val[vv] : 1'($urandom());
      end else begin
         vs_unassign = 1'($urandom());
         vs_val      = 1'($urandom());
      end
   endtask

   task automatic idle(int unsigned n);
      bcp_en = 1'b0;
      repeat (n) step();
   endtask

   task automatic issue(int unsigned idx);
      bcp_en = 1'b1; bcp_clause_idx = CB'(idx);
      step();
      bcp_en = 1'b0;
   endtask

   task automatic drain();
      int unsigned guard = 0;
      while ((mq.size() != 0 || cyc < m_free || m_pend) && guard < 200) begin
         step(); guard++;
      end
      check("drain_timeout", 32'(guard >= 200), 32'd0);
   endtask

   task automatic clr_counts();
      n_cdb = 0; n_vs = 0; n_push = 0; n_busy0 = 0; pop_cyc.delete();
   endtask

   task automatic pulse_reset_bcp();
      reset_bcp = 1'b1;
      step();
      reset_bcp = 1'b0;
   endtask

   function automatic logic [31:0] all_outs();
      return {bcp_busy, conflict, overflow, cdb_read, cdb_idx, vs_read, vs_var,
              push_imply, var_in_imply, val_in_imply, type_in_imply};
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; reset_bcp = 1'b0; bcp_en = 1'b0; bcp_clause_idx = '0;
      cdb_lits = '0; vs_val = 1'b0; vs_unassign = 1'b0; full_imply = 1'b0;
      for (int i = 0; i < 256; i++) begin db[i] = '0; asg[i] = 1'b1; val[i] = 1'b0; end
      m_conf = 0; m_ovf = 0; m_pend = 0; m_free = 0; m_conf_at = -1; m_ppol = 0;
      m_pend_from = 0; m_pvar = 0;
      clr_counts();
      repeat (2) @(posedge clock);
      #1;
      step();
      check("reset_outs", all_outs(), 32'd0);
      reset = 1'b0;
      idle(2);

      // unit clause: var3 unassigned, var5 = 0
      asg[3] = 1'b0; asg[5] = 1'b1; val[5] = 1'b0;
      db[7] = {lit(0, 0, 0), lit(1, 1, 5), lit(1, 1, 3)};
      clr_counts(); issue(7); drain(); idle(1);
      check("unit_push_count", n_push, 32'd1);
      check("unit_conflict", 32'(conflict), 32'd0);
      check("unit_busy_after", 32'(bcp_busy), 32'd0);

      // conflict followed by three more indices
      asg[2] = 1'b1; val[2] = 1'b1; asg[4] = 1'b1; val[4] = 1'b1;
      db[9] = {lit(1, 0, 4), lit(1, 0, 4), lit(1, 0, 2)};
      clr_counts(); issue(9); issue(7); issue(7); issue(7); drain();
      check("conf_flag", 32'(conflict), 32'd1);
      check("conf_reads", n_cdb, 32'd1);
      check("conf_push", n_push, 32'd0);
      check("conf_busy_next", 32'(bcp_busy), 32'd0);
      issue(7); idle(3);
      check("conf_no_ovf", 32'(overflow), 32'd0);
      check("conf_hold", 32'(conflict), 32'd1);
      check("conf_discard", n_cdb, 32'd1);
      pulse_reset_bcp(); idle(1);
      check("conf_cleared", 32'(conflict), 32'd0);

      // early exit on a true slot 0, two clauses back to back
      asg[6] = 1'b1; val[6] = 1'b1;
      db[11] = {lit(0, 0, 0), lit(1, 0, 5), lit(1, 1, 6)};
      clr_counts(); issue(11); issue(11); drain();
      check("early_vs_reads", n_vs, 32'd2);
      check("early_push", n_push, 32'd0);
      check("early_pop_gap", (pop_cyc.size() == 2) ? pop_cyc[1] - pop_cyc[0] : 0, 32'd4);

      // back-pressure: five stall cycles in PUSH
      clr_counts(); full_imply = 1'b1; issue(7); idle(13);
      check("bp_no_push_while_full", n_push, 32'd0);
      full_imply = 1'b0; drain();
      check("bp_push_count", n_push, 32'd1);

      // overflow: ten back-to-back indices of an unresolved clause
      asg[10] = 1'b0; asg[11] = 1'b0; asg[12] = 1'b0;
      db[20] = {lit(1, 0, 10), lit(1, 1, 11), lit(1, 0, 12)};
      clr_counts(); bcp_en = 1'b1; bcp_clause_idx = CB'(20);
      repeat (10) step();
      bcp_en = 1'b0; drain();
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_evaluated", n_cdb, 32'd9);
      check("ovf_busy_gap", n_busy0, 32'd0);
      pulse_reset_bcp(); idle(1);
      check("ovf_cleared", 32'(overflow), 32'd0);

      // reset_bcp during LIT_CHK, then during a stalled PUSH
      clr_counts(); issue(20); idle(3);
      reset_bcp = 1'b1; step(); reset_bcp = 1'b0;
      check("rst_mid_outs", all_outs(), 32'd0);
      idle(2);
      clr_counts(); full_imply = 1'b1; issue(7); idle(9);
      full_imply = 1'b0; reset_bcp = 1'b1; step(); reset_bcp = 1'b0;
      check("rst_push_outs", all_outs(), 32'd0);
      idle(3);
      check("rst_push_abort", n_push, 32'd0);

      // random traffic over random clauses and assignments
      for (int seg = 0; seg < 4; seg++) begin
         for (int i = 0; i < 16; i++) begin
            asg[i] = ($urandom_range(0, 9) < 6);
            val[i] = 1'($urandom());
         end
         for (int i = 32; i < 64; i++) begin
            for (int s = 0; s < LITS; s++)
               rw[s*SW +: SW] = lit($urandom_range(0, 9) < 8, 1'($urandom()),
                                    $urandom_range(0, 15));
            db[i] = rw;
         end
         for (int n = 0; n < 500; n++) begin
            bcp_en         = ($urandom_range(0, 99) < 35);
            bcp_clause_idx = CB'($urandom_range(32, 63));
            full_imply     = ($urandom_range(0, 99) < 30);
            reset_bcp      = ($urandom_range(0, 99) < 2);
            reset          = ($urandom_range(0, 499) == 0);
            step();
         end
         reset = 1'b0; reset_bcp = 1'b0; bcp_en = 1'b0; full_imply = 1'b0;
         drain();
         pulse_reset_bcp();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
